// File: rtl/dma_mem_tester.sv
// DMA memory tester: writes an address-tagged pattern over a region in bursts, reads it back and counts mismatching beats.
// Optional watchdog enabled by defining DMA_MEM_TESTER_TIMEOUT_EN.
module dma_mem_tester #(
    parameter int unsigned caddr_width_p    = 28,
    parameter int unsigned data_width_p     = 64,
    parameter int unsigned burst_len_p      = 8,
    parameter int unsigned base_addr_p      = 'h100,
    parameter int unsigned num_bursts_p     = 16,
    parameter logic [31:0] pattern_p        = 32'hDEADBEEF,
    parameter int unsigned timeout_cycles_p = 4096
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     start_i,
    output logic [caddr_width_p:0]   dma_pkt_o,
    output logic                     dma_pkt_v_o,
    input  logic                     dma_pkt_yumi_i,
    output logic [data_width_p-1:0]  dma_data_o,
    output logic                     dma_data_v_o,
    input  logic                     dma_data_yumi_i,
    input  logic [data_width_p-1:0]  dma_data_i,
    input  logic                     dma_data_v_i,
    output logic                     dma_data_ready_and_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pass_o,
    output logic [15:0]              error_count_o,
    output logic [caddr_width_p-1:0] first_err_addr_o
);

    localparam int unsigned BEAT_BYTES  = data_width_p / 8;
    localparam int unsigned BURST_BYTES = burst_len_p * BEAT_BYTES;
    localparam int unsigned IDX_W  = (num_bursts_p > 1) ? $clog2(num_bursts_p) : 1;
    localparam int unsigned BEAT_W = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;

    typedef enum logic [2:0] {IDLE, WR_PKT, WR_DATA, RD_PKT, RD_DATA, DONE} state_e;

    state_e                   state_q;
    logic [IDX_W-1:0]         burst_idx_q;
    logic [BEAT_W-1:0]        beat_q;
    logic [caddr_width_p:0]   pkt_q;
    logic                     pkt_v_q;
    logic [data_width_p-1:0]  data_q;
    logic                     data_v_q;
    logic                     ready_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     pass_q;
    logic [15:0]              err_q;
    logic [caddr_width_p-1:0] first_err_q;

    logic [caddr_width_p-1:0] burst_addr_d, next_burst_addr_d, beat_addr_d, next_beat_addr_d;
    logic                     last_beat_d, last_burst_d;
    logic                     pkt_hs_d, wr_hs_d, rd_hs_d, mism_d;

    function automatic logic [data_width_p-1:0] word_f(input logic [caddr_width_p-1:0] a);
        return data_width_p'({32'(a), pattern_p});
    endfunction

    always_comb begin
        burst_addr_d      = caddr_width_p'(base_addr_p)
                          + caddr_width_p'(burst_idx_q) * caddr_width_p'(BURST_BYTES);
        next_burst_addr_d = burst_addr_d + caddr_width_p'(BURST_BYTES);
        beat_addr_d       = burst_addr_d + caddr_width_p'(beat_q) * caddr_width_p'(BEAT_BYTES);
        next_beat_addr_d  = beat_addr_d + caddr_width_p'(BEAT_BYTES);
        last_beat_d       = (beat_q == BEAT_W'(burst_len_p - 1));
        last_burst_d      = (burst_idx_q == IDX_W'(num_bursts_p - 1));
        pkt_hs_d          = pkt_v_q & dma_pkt_yumi_i;
        wr_hs_d           = data_v_q & dma_data_yumi_i;
        rd_hs_d           = ready_q & dma_data_v_i;
        mism_d            = rd_hs_d && (dma_data_i != word_f(beat_addr_d));
    end

`ifdef DMA_MEM_TESTER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(timeout_cycles_p + 1);
    logic [WD_W-1:0] wd_q;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            burst_idx_q <= '0;
            beat_q      <= '0;
            pkt_q       <= '0;
            pkt_v_q     <= 1'b0;
            data_q      <= '0;
            data_v_q    <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_err_q <= '0;
`ifdef DMA_MEM_TESTER_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q     <= WR_PKT;
                        burst_idx_q <= '0;
                        beat_q      <= '0;
                        err_q       <= '0;
                        first_err_q <= '0;
                        pass_q      <= 1'b0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        pkt_v_q     <= 1'b1;
                        pkt_q       <= {1'b1, caddr_width_p'(base_addr_p)};
                    end
                end
                WR_PKT: begin
                    if (pkt_hs_d) begin
                        state_q  <= WR_DATA;
                        pkt_v_q  <= 1'b0;
                        beat_q   <= '0;
                        data_v_q <= 1'b1;
                        data_q   <= word_f(burst_addr_d);
                    end
                end
                WR_DATA: begin
                    if (wr_hs_d) begin
                        if (!last_beat_d) begin
                            beat_q <= beat_q + BEAT_W'(1);
                            data_q <= word_f(next_beat_addr_d);
                        end else begin
                            data_v_q <= 1'b0;
                            beat_q   <= '0;
                            pkt_v_q  <= 1'b1;
                            if (!last_burst_d) begin
                                burst_idx_q <= burst_idx_q + IDX_W'(1);
                                pkt_q       <= {1'b1, next_burst_addr_d};
                                state_q     <= WR_PKT;
                            end else begin
                                burst_idx_q <= '0;
                                pkt_q       <= {1'b0, caddr_width_p'(base_addr_p)};
                                state_q     <= RD_PKT;
                            end
                        end
                    end
                end
                RD_PKT: begin
                    if (pkt_hs_d) begin
                        state_q <= RD_DATA;
                        pkt_v_q <= 1'b0;
                        ready_q <= 1'b1;
                        beat_q  <= '0;
                    end
                end
                RD_DATA: begin
                    if (rd_hs_d) begin
                        if (mism_d) begin
                            if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
                            if (err_q == '0) first_err_q <= beat_addr_d;
                        end
                        if (!last_beat_d) begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end else begin
                            ready_q <= 1'b0;
                            beat_q  <= '0;
                            if (!last_burst_d) begin
                                burst_idx_q <= burst_idx_q + IDX_W'(1);
                                pkt_v_q     <= 1'b1;
                                pkt_q       <= {1'b0, next_burst_addr_d};
                                state_q     <= RD_PKT;
                            end else begin
                                state_q <= DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                // Final beat's mismatch is not yet in err_q.
                                pass_q  <= (err_q == '0) && !mism_d;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef DMA_MEM_TESTER_TIMEOUT_EN
            // Placed after the case so an expiry overrides any transition this cycle.
            if (!busy_q || pkt_hs_d || wr_hs_d || rd_hs_d) begin
                wd_q <= '0;
            end else if (wd_q == WD_W'(timeout_cycles_p - 1)) begin
                state_q  <= DONE;
                pkt_v_q  <= 1'b0;
                data_v_q <= 1'b0;
                ready_q  <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                pass_q   <= 1'b0;
                err_q    <= '1;
                wd_q     <= '0;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
`endif
        end
    end

    assign dma_pkt_o            = pkt_q;
    assign dma_pkt_v_o          = pkt_v_q;
    assign dma_data_o           = data_q;
    assign dma_data_v_o         = data_v_q;
    assign dma_data_ready_and_o = ready_q;
    assign busy_o               = busy_q;
    assign done_o               = done_q;
    assign pass_o               = pass_q;
    assign error_count_o        = err_q;
    assign first_err_addr_o     = first_err_q;

endmodule
